// File: rtl/ct_spsram_req_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
package ct_spsram_req_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned RSP_DEPTH = 2;
    // Wide enough to hold buffered + in-flight reads (max RSP_DEPTH + 1).
    localparam int unsigned CREDIT_W  = 2;

endpackage

// File: rtl/ct_spsram_req_ctrl_if.sv
// Request/response channel plus SRAM macro pins; slave = controller, master = requester/macro side.
interface ct_spsram_req_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 144
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        output req_rdy, rsp_vld, rsp_rdata, init_done,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        input  req_rdy, rsp_vld, rsp_rdata, init_done,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

endinterface

// File: rtl/ct_spsram_rsp_buf.sv
// Two-entry in-order read-response FIFO; data storage is not reset.
module ct_spsram_rsp_buf
    import ct_spsram_req_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 144
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CREDIT_W-1:0]   occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [CREDIT_W-1:0]   cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + CREDIT_W'(push_i) - CREDIT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CREDIT_W'(RSP_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign occ_o   = cnt_q;

endmodule

// File: rtl/ct_spsram_req_ctrl.sv
// Initiator-side controller for an active-low single-port SRAM macro with 1-cycle read latency.
module ct_spsram_req_ctrl
    import ct_spsram_req_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 144,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    ct_spsram_req_ctrl_if.slave  bus
);

    localparam state_e RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  init_done_q, init_done_d;
    logic                  req_rdy_q, req_rdy_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  accept, pop, sweep, sweep_last;
    logic                  buf_full, buf_empty;
    logic [CREDIT_W-1:0]   occ, occ_next, credit_next;

    assign sweep_last    = (state_q == ST_INIT) && (&init_cnt_q);
    // Macro pins are combinational; gating with reset keeps CEN high while reset is held.
    assign sweep         = (state_q == ST_INIT) && !cpurst;
    assign accept        = bus.req_vld && req_rdy_q;
    assign pop           = !buf_empty && bus.rsp_rdy;
    assign rd_inflight_d = accept && !bus.req_wr;
    assign init_done_d   = (state_q == ST_RUN) || sweep_last;
    assign occ_next      = occ + CREDIT_W'(rd_inflight_q) - CREDIT_W'(pop);
    assign credit_next   = occ_next + CREDIT_W'(rd_inflight_d);
    assign req_rdy_d     = init_done_d && (credit_next < CREDIT_W'(RSP_DEPTH));

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q       <= RST_STATE;
            init_cnt_q    <= '0;
            init_done_q   <= 1'b0;
            req_rdy_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (sweep_last) state_q <= ST_RUN;
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= RST_STATE;
            endcase
            init_done_q   <= init_done_d;
            req_rdy_q     <= req_rdy_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    always_comb begin
        bus.sram_cen  = 1'b1;
        bus.sram_gwen = 1'b1;
        bus.sram_wen  = '1;
        bus.sram_a    = '0;
        bus.sram_d    = '0;
        if (sweep) begin
            bus.sram_cen  = 1'b0;
            bus.sram_gwen = 1'b0;
            bus.sram_wen  = '0;
            bus.sram_a    = init_cnt_q;
        end else if (accept) begin
            bus.sram_cen = 1'b0;
            bus.sram_a   = bus.req_addr;
            if (bus.req_wr) begin
                bus.sram_gwen = 1'b0;
                bus.sram_wen  = ~bus.req_wmask;
                bus.sram_d    = bus.req_wdata;
            end
        end
    end

    ct_spsram_rsp_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_buf (
        .clk_i   (forever_cpuclk),
        .rst_i   (cpurst),
        .push_i  (rd_inflight_q),
        .data_i  (bus.sram_q),
        .pop_i   (pop),
        .data_o  (bus.rsp_rdata),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .occ_o   (occ)
    );

    assign bus.req_rdy   = req_rdy_q;
    assign bus.rsp_vld   = !buf_empty;
    assign bus.init_done = init_done_q;

    a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(rd_inflight_q && buf_full && !pop));

endmodule

// File: tb/tb_ct_spsram_req_ctrl.sv
// Randomized scoreboard bench for ct_spsram_req_ctrl with a behavioural SRAM macro and reference memory.
module tb_ct_spsram_req_ctrl;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 144;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ct_spsram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_spsram_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_EN    (1'b1)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: active-low controls, per-bit write enable, registered Q.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_gwen)
                sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) |
                                        (bus.sram_d & ~bus.sram_wen);
            else
                bus.sram_q <= sram_mem[bus.sram_a];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v = (v << 32) | DW'($urandom());
        return v;
    endfunction

    // Reference model: what memory should hold and which reads are owed.
    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          sb[$];
    int            cyc = 0;
    int            outstanding = 0;
    int            acc_cnt = 0;
    bit            run_chk = 0;
    bit            have_exp_rdy = 0;
    bit            exp_rdy;
    bit            prev_vld = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (run_chk && !rst) begin
            bit   acc, rd, pop;
            exp_t e;
            if (have_exp_rdy) chk("req_rdy_credit", DW'(bus.req_rdy), DW'(exp_rdy));
            acc = bus.req_vld && bus.req_rdy;
            rd  = acc && !bus.req_wr;
            pop = bus.rsp_vld && bus.rsp_rdy;
            if (bus.rsp_vld) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", DW'(bus.rsp_vld), '0);
                end else begin
                    if (!prev_vld) chk("rsp_latency", DW'(cyc), DW'(sb[0].cyc + 2));
                    if (pop) begin
                        e = sb.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, e.data);
                    end
                end
            end
            if (acc) begin
                acc_cnt++;
                chk("acc_cen", DW'(bus.sram_cen), '0);
                chk("acc_a", DW'(bus.sram_a), DW'(bus.req_addr));
                chk("acc_gwen", DW'(bus.sram_gwen), DW'(!bus.req_wr));
                if (bus.req_wr) begin
                    chk("acc_wen", bus.sram_wen, ~bus.req_wmask);
                    chk("acc_d", bus.sram_d, bus.req_wdata);
                    ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask) |
                                            (bus.req_wdata & bus.req_wmask);
                end else begin
                    chk("acc_wen_rd", bus.sram_wen, '1);
                    e.data = ref_mem[bus.req_addr];
                    e.cyc  = cyc;
                    sb.push_back(e);
                end
            end else begin
                chk("idle_cen", DW'(bus.sram_cen), DW'(1));
            end
            outstanding  = outstanding + int'(rd) - int'(pop);
            exp_rdy      = (outstanding < 2);
            have_exp_rdy = 1;
            prev_vld     = bus.rsp_vld;
        end else begin
            have_exp_rdy = 0;
            prev_vld     = 0;
            outstanding  = 0;
            sb.delete();
        end
    end

    task automatic idle_inputs();
        bus.req_vld   = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
    endtask

    task automatic sweep_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("sweep_a", DW'(bus.sram_a), DW'(i));
            chk("sweep_cen", DW'(bus.sram_cen), '0);
            chk("sweep_gwen", DW'(bus.sram_gwen), '0);
            chk("sweep_wen", bus.sram_wen, '0);
            chk("sweep_d", bus.sram_d, '0);
            chk("sweep_init_done", DW'(bus.init_done), '0);
            chk("sweep_req_rdy", DW'(bus.req_rdy), '0);
        end
        if (n == int'(DEPTH)) begin
            @(negedge clk);
            chk("post_sweep_init_done", DW'(bus.init_done), DW'(1));
            chk("post_sweep_req_rdy", DW'(bus.req_rdy), DW'(1));
        end
    endtask

    task automatic do_reset();
        run_chk = 0;
        rst = 1'b1;
        #1;
        chk("rst_rsp_vld", DW'(bus.rsp_vld), '0);
        chk("rst_init_done", DW'(bus.init_done), '0);
        chk("rst_req_rdy", DW'(bus.req_rdy), '0);
        chk("rst_cen", DW'(bus.sram_cen), DW'(1));
        chk("rst_wen", bus.sram_wen, '1);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_run();
        @(posedge clk);
        #1 run_chk = 1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        int n = 0;
        while (!bus.req_rdy && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("issue_rdy_wait", DW'(bus.req_rdy), DW'(1));
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic drain();
        int n = 0;
        bus.rsp_rdy = 1'b1;
        idle_inputs();
        while ((outstanding != 0 || sb.size() != 0) && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_done", DW'(sb.size()), '0);
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] a5;
        logic [DW-1:0] lowmask;
        int            acc_before;
        ones    = '1;
        a5      = {18{8'hA5}};
        lowmask = DW'(8'hFF);

        for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] = rnd_data();
        bus.sram_q  = '0;
        bus.rsp_rdy = 1'b1;
        idle_inputs();

        // Initial reset and full zero-fill sweep.
        do_reset();
        sweep_check(int'(DEPTH));
        start_run();

        // Full-mask write then read-back, plus an untouched address.
        issue(1'b1, 8'h12, a5, ones);
        issue(1'b0, 8'h12, '0, '0);
        issue(1'b0, 8'h40, '0, '0);
        drain();

        // Masked write over all-ones data.
        issue(1'b1, 8'h20, ones, ones);
        issue(1'b1, 8'h20, '0, lowmask);
        issue(1'b0, 8'h20, '0, '0);
        drain();

        // Back-to-back reads with the response side stalled.
        bus.rsp_rdy = 1'b0;
        acc_before = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.req_vld  = 1'b1;
            bus.req_wr   = 1'b0;
            bus.req_addr = AW'(8'h10 + i);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(posedge clk);
        #1;
        chk("b2b_accepts", DW'(acc_cnt - acc_before), DW'(2));
        chk("b2b_rsp_vld", DW'(bus.rsp_vld), DW'(1));
        drain();

        // Read A then write B on the very next cycle.
        issue(1'b1, 8'h30, a5, ones);
        issue(1'b0, 8'h30, '0, '0);
        issue(1'b1, 8'h31, ~a5, ones);
        issue(1'b0, 8'h31, '0, '0);
        drain();

        // Randomized traffic over a small hot address range.
        for (int i = 0; i < 2000; i++) begin
            bus.req_vld   = ($urandom_range(0, 3) != 0);
            bus.req_wr    = $urandom_range(0, 1) == 1;
            bus.req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15));
            bus.req_wdata = rnd_data();
            bus.req_wmask = ($urandom_range(0, 1) == 1) ? ones : rnd_data();
            bus.rsp_rdy   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Reset in the middle of the sweep, at count 100.
        do_reset();
        sweep_check(100);
        @(posedge clk);
        #1;
        chk("sweep_cnt100", DW'(bus.sram_a), DW'(100));
        do_reset();
        sweep_check(int'(DEPTH));
        start_run();

        // Reset with two buffered responses.
        issue(1'b1, 8'h05, a5, ones);
        bus.rsp_rdy = 1'b0;
        issue(1'b0, 8'h05, '0, '0);
        issue(1'b0, 8'h06, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_rsp_vld", DW'(bus.rsp_vld), DW'(1));
        do_reset();
        sweep_check(int'(DEPTH));
        start_run();
        bus.rsp_rdy = 1'b1;
        issue(1'b0, 8'h05, '0, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
